locked_ckt_query_sched: RTL and testbench

//  Sequences input-pattern/key queries into a combinational key-locked circuit
//  (c432-class: 36 PIs, 32 key bits, 7 POs) and its unlocked oracle copy.
//  Two requesters share the circuit through a round-robin arbiter; either can be the

---
 rtl/locked_ckt_query_sched_if.sv | 44 ++++
 rtl/locked_ckt_query_sched.sv | 123 ++++++++++++
 tb/tb_locked_ckt_query_sched.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/locked_ckt_query_sched_if.sv
// Query/response bundle between the requesters, the locked circuit pair and the consumer.
// slave is the scheduler side and master is the environment side.
interface locked_ckt_query_sched_if #(
  parameter int PI_W  = 36,
  parameter int KEY_W = 32,
  parameter int PO_W  = 7,
  parameter int CNT_W = 16
);
  logic             req0_valid;
  logic             req0_ready;
  logic [PI_W-1:0]  req0_pi;
  logic [KEY_W-1:0] req0_key;
  logic             req1_valid;
  logic             req1_ready;
  logic [PI_W-1:0]  req1_pi;
  logic [KEY_W-1:0] req1_key;
  logic [PI_W-1:0]  ckt_pi;
  logic [KEY_W-1:0] ckt_key;
  logic [PO_W-1:0]  ckt_po;
  logic [PO_W-1:0]  orc_po;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [PO_W-1:0]  rsp_po;
  logic [PO_W-1:0]  rsp_orc_po;
  logic             rsp_mismatch;
  logic             busy;
  logic [CNT_W-1:0] query_cnt;
  logic [CNT_W-1:0] mismatch_cnt;

  modport slave (
    input  req0_valid, req0_pi, req0_key, req1_valid, req1_pi, req1_key,
           ckt_po, orc_po, rsp_ready,
    output req0_ready, req1_ready, ckt_pi, ckt_key, rsp_valid, rsp_id, rsp_po,
           rsp_orc_po, rsp_mismatch, busy, query_cnt, mismatch_cnt
  );

  modport master (
    output req0_valid, req0_pi, req0_key, req1_valid, req1_pi, req1_key,
           ckt_po, orc_po, rsp_ready,
    input  req0_ready, req1_ready, ckt_pi, ckt_key, rsp_valid, rsp_id, rsp_po,
           rsp_orc_po, rsp_mismatch, busy, query_cnt, mismatch_cnt
  );
endinterface

// File: rtl/locked_ckt_query_sched.sv
// Round-robin query scheduler for a key-locked circuit and its oracle: drive, settle,
// capture both output vectors, and return them over a valid/ready response channel.
module locked_ckt_query_sched #(
  parameter int PI_W   = 36,
  parameter int KEY_W  = 32,
  parameter int PO_W   = 7,
  parameter int SETTLE = 2,
  parameter int CNT_W  = 16
) (
  input logic clk,
  input logic rst,
  locked_ckt_query_sched_if.slave bus
);
  typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;

  typedef struct packed {
    logic            id;
    logic [PO_W-1:0] po;
    logic [PO_W-1:0] orc_po;
    logic            mismatch;
  } rsp_t;

  localparam logic [7:0]       SETTLE_LD = 8'(SETTLE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t                state, nstate;
  logic [1:0]            vld;
  logic [1:0][PI_W-1:0]  pi_in;
  logic [1:0][KEY_W-1:0] key_in;
  logic                  grant, last_grant, accept, hshk;
  logic [7:0]            settle_cnt;
  logic [PI_W-1:0]       pi_q;
  logic [KEY_W-1:0]      key_q;
  rsp_t                  rsp_q;
  logic [CNT_W-1:0]      query_cnt_q, mismatch_cnt_q;

  assign vld    = {bus.req1_valid, bus.req0_valid};
  assign pi_in  = {bus.req1_pi, bus.req0_pi};
  assign key_in = {bus.req1_key, bus.req0_key};
  // Contention goes to whoever did not win last; a lone requester always wins.
  assign grant  = (&vld) ? ~last_grant : vld[1];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (|vld) nstate = DRIVE;
      DRIVE:   if (settle_cnt == '0) nstate = RESP;
      RESP:    if (bus.rsp_ready) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    accept         = 1'b0;
    hshk           = 1'b0;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.rsp_valid  = 1'b0;
    bus.busy       = 1'b0;
    case (state)
      IDLE: begin
        accept         = |vld;
        bus.req0_ready = vld[0] & ~grant;
        bus.req1_ready = grant;
      end
      DRIVE: bus.busy = 1'b1;
      RESP: begin
        bus.busy      = 1'b1;
        bus.rsp_valid = 1'b1;
        hshk          = bus.rsp_ready;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant     <= 1'b1;
      settle_cnt     <= '0;
      pi_q           <= '0;
      key_q          <= '0;
      rsp_q          <= '0;
      query_cnt_q    <= '0;
      mismatch_cnt_q <= '0;
    end else begin
      if (accept) begin
        pi_q       <= pi_in[grant];
        key_q      <= key_in[grant];
        rsp_q.id   <= grant;
        last_grant <= grant;
        settle_cnt <= SETTLE_LD;
      end else if (state == DRIVE) begin
        // Capture on the last settle cycle; rsp_q then holds through backpressure.
        if (settle_cnt == '0) begin
          rsp_q.po       <= bus.ckt_po;
          rsp_q.orc_po   <= bus.orc_po;
          rsp_q.mismatch <= (bus.ckt_po != bus.orc_po);
        end else begin
          settle_cnt <= settle_cnt - 8'd1;
        end
      end
      if (hshk) begin
        if (query_cnt_q != '1) query_cnt_q <= query_cnt_q + CNT_ONE;
        if (rsp_q.mismatch && (mismatch_cnt_q != '1))
          mismatch_cnt_q <= mismatch_cnt_q + CNT_ONE;
      end
    end
  end

  assign bus.ckt_pi       = pi_q;
  assign bus.ckt_key      = key_q;
  assign bus.rsp_id       = rsp_q.id;
  assign bus.rsp_po       = rsp_q.po;
  assign bus.rsp_orc_po   = rsp_q.orc_po;
  assign bus.rsp_mismatch = rsp_q.mismatch;
  assign bus.query_cnt    = query_cnt_q;
  assign bus.mismatch_cnt = mismatch_cnt_q;
endmodule

// File: tb/tb_locked_ckt_query_sched.sv
// Two scheduler instances (SETTLE=2/CNT_W=16 and SETTLE=4/CNT_W=2) driven by directed
// and random queries; the circuit/oracle pair is a key-dependent XOR of ckt_pi/ckt_key.
module tb_locked_ckt_query_sched;
  localparam int PI_W = 36, KEY_W = 32, PO_W = 7;
  localparam int SET_A = 2, SET_B = 4, CW_A = 16, CW_B = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst;
  logic             r0v[2], r1v[2], rrdy[2];
  logic [PI_W-1:0]  r0pi[2], r1pi[2];
  logic [KEY_W-1:0] r0key[2], r1key[2];
  logic [PO_W-1:0]  cx[2], ox[2];

  logic             o_r0rdy[2], o_r1rdy[2], o_rv[2], o_rid[2], o_rmis[2], o_busy[2];
  logic [PO_W-1:0]  o_rpo[2], o_rorc[2];
  logic [PI_W-1:0]  o_pi[2];
  logic [KEY_W-1:0] o_key[2];
  logic [15:0]      o_qc[2], o_mc[2];

  for (genvar d = 0; d < 2; d++) begin : g
    localparam int CW = (d == 0) ? CW_A : CW_B;
    localparam int ST = (d == 0) ? SET_A : SET_B;
    locked_ckt_query_sched_if #(.PI_W(PI_W), .KEY_W(KEY_W), .PO_W(PO_W), .CNT_W(CW)) bus ();
    locked_ckt_query_sched #(.PI_W(PI_W), .KEY_W(KEY_W), .PO_W(PO_W), .SETTLE(ST), .CNT_W(CW))
      dut (.clk(clk), .rst(rst[d]), .bus(bus));
    assign bus.req0_valid = r0v[d];
    assign bus.req0_pi    = r0pi[d];
    assign bus.req0_key   = r0key[d];
    assign bus.req1_valid = r1v[d];
    assign bus.req1_pi    = r1pi[d];
    assign bus.req1_key   = r1key[d];
    assign bus.rsp_ready  = rrdy[d];
    // Locked copy differs from the oracle by key bits and a per-test offset.
    assign bus.ckt_po = bus.ckt_pi[PO_W-1:0] ^ bus.ckt_key[PO_W-1:0] ^ cx[d];
    assign bus.orc_po = bus.ckt_pi[PO_W-1:0] ^ ox[d];
    assign o_r0rdy[d] = bus.req0_ready;
    assign o_r1rdy[d] = bus.req1_ready;
    assign o_rv[d]    = bus.rsp_valid;
    assign o_rid[d]   = bus.rsp_id;
    assign o_rmis[d]  = bus.rsp_mismatch;
    assign o_busy[d]  = bus.busy;
    assign o_rpo[d]   = bus.rsp_po;
    assign o_rorc[d]  = bus.rsp_orc_po;
    assign o_pi[d]    = bus.ckt_pi;
    assign o_key[d]   = bus.ckt_key;
    assign o_qc[d]    = 16'(bus.query_cnt);
    assign o_mc[d]    = 16'(bus.mismatch_cnt);
  end

  // Reference model state per instance.
  logic             lastg[2];
  logic [PI_W-1:0]  lastpi[2];
  logic [KEY_W-1:0] lastkey[2];
  int               mqc[2], mmc[2], maxc[2];
  int               ncmp = 0, nerr = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset(input int d);
    lastg[d] = 1'b1; lastpi[d] = '0; lastkey[d] = '0; mqc[d] = 0; mmc[d] = 0;
  endtask

  task automatic chk_idle(input int d, input logic v0, input logic v1, input logic g);
    chk("idle_rsp_valid", 64'(o_rv[d]), 0);
    chk("idle_busy", 64'(o_busy[d]), 0);
    chk("ckt_pi_hold", 64'(o_pi[d]), 64'(lastpi[d]));
    chk("ckt_key_hold", 64'(o_key[d]), 64'(lastkey[d]));
    chk("query_cnt", 64'(o_qc[d]), 64'(mqc[d]));
    chk("mismatch_cnt", 64'(o_mc[d]), 64'(mmc[d]));
    chk("req0_ready", 64'(o_r0rdy[d]), 64'(v0 & ~g));
    chk("req1_ready", 64'(o_r1rdy[d]), 64'(v1 & g));
  endtask

  task automatic idle(input int d, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      r0v[d] = 1'b0; r1v[d] = 1'b0; rrdy[d] = 1'b0;
      #1;
      chk_idle(d, 1'b0, 1'b0, 1'b0);
    end
  endtask

  // One full query: accept cycle, SETTLE drive cycles, stall+1 response cycles.
  task automatic query(input int d, input logic v0, input logic v1, input int stall);
    int st;
    logic g;
    logic [PI_W-1:0] epi;
    logic [KEY_W-1:0] ekey;
    logic [PO_W-1:0] epo, eorc;
    st = (d == 0) ? SET_A : SET_B;
    g = (v0 & v1) ? ~lastg[d] : v1;
    @(negedge clk);
    r0v[d] = v0; r1v[d] = v1; rrdy[d] = 1'b0;
    #1;
    chk_idle(d, v0, v1, g);
    epi  = g ? r1pi[d] : r0pi[d];
    ekey = g ? r1key[d] : r0key[d];
    lastg[d] = g; lastpi[d] = epi; lastkey[d] = ekey;
    epo  = epi[PO_W-1:0] ^ ekey[PO_W-1:0] ^ cx[d];
    eorc = epi[PO_W-1:0] ^ ox[d];
    for (int k = 1; k <= st; k++) begin
      @(negedge clk); #1;
      chk("drive_ready0", 64'(o_r0rdy[d]), 0);
      chk("drive_ready1", 64'(o_r1rdy[d]), 0);
      chk("drive_busy", 64'(o_busy[d]), 1);
      chk("drive_rsp_valid", 64'(o_rv[d]), 0);
      chk("drive_ckt_pi", 64'(o_pi[d]), 64'(epi));
      chk("drive_ckt_key", 64'(o_key[d]), 64'(ekey));
    end
    for (int k = 0; k <= stall; k++) begin
      @(negedge clk);
      rrdy[d] = (k == stall);
      if (k > 0) begin
        cx[d] = 7'($urandom); ox[d] = 7'($urandom);
      end
      #1;
      chk("rsp_valid", 64'(o_rv[d]), 1);
      chk("rsp_id", 64'(o_rid[d]), 64'(g));
      chk("rsp_po", 64'(o_rpo[d]), 64'(epo));
      chk("rsp_orc_po", 64'(o_rorc[d]), 64'(eorc));
      chk("rsp_mismatch", 64'(o_rmis[d]), 64'(epo != eorc));
      chk("resp_ready0", 64'(o_r0rdy[d]), 0);
      chk("resp_ready1", 64'(o_r1rdy[d]), 0);
      chk("resp_busy", 64'(o_busy[d]), 1);
      chk("resp_query_cnt", 64'(o_qc[d]), 64'(mqc[d]));
      chk("resp_mismatch_cnt", 64'(o_mc[d]), 64'(mmc[d]));
    end
    if (mqc[d] < maxc[d]) mqc[d]++;
    if ((epo != eorc) && (mmc[d] < maxc[d])) mmc[d]++;
  endtask

  // Accept a req0 query, then reset during cycle T+at.
  task automatic reset_mid(input int d, input int at);
    @(negedge clk);
    r0v[d] = 1'b1; r1v[d] = 1'b0; rrdy[d] = 1'b0;
    #1;
    chk("rst_mid_accept", 64'(o_r0rdy[d]), 1);
    for (int k = 1; k < at; k++) @(negedge clk);
    rst[d] = 1'b1; r0v[d] = 1'b0;
    @(negedge clk);
    rst[d] = 1'b0;
    #1;
    model_reset(d);
    chk("rst_mid_rsp_valid", 64'(o_rv[d]), 0);
    chk("rst_mid_busy", 64'(o_busy[d]), 0);
    chk("rst_mid_ckt_pi", 64'(o_pi[d]), 0);
    chk("rst_mid_ckt_key", 64'(o_key[d]), 0);
    chk("rst_mid_query_cnt", 64'(o_qc[d]), 0);
    chk("rst_mid_mismatch_cnt", 64'(o_mc[d]), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] vv;
    maxc[0] = (1 << CW_A) - 1;
    maxc[1] = (1 << CW_B) - 1;
    rst = 2'b11;
    for (int d = 0; d < 2; d++) begin
      r0v[d] = 0; r1v[d] = 0; rrdy[d] = 0; r0pi[d] = '0; r1pi[d] = '0;
      r0key[d] = '0; r1key[d] = '0; cx[d] = '0; ox[d] = '0;
      model_reset(d);
    end
    repeat (3) @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) chk_idle(d, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 2'b00;

    // Contention held over three queries: grants alternate starting with requester 0.
    r0pi[0] = 36'h1_2345_6789; r0key[0] = 32'hdead_beef;
    r1pi[0] = 36'h9_8765_4321; r1key[0] = 32'hcafe_f00d;
    cx[0] = 7'h11; ox[0] = 7'h22;
    for (int i = 0; i < 3; i++) query(0, 1'b1, 1'b1, 0);
    idle(0, 1);

    // Single query with matching outputs 0x55.
    r0pi[0] = 36'h0_0000_0001; r0key[0] = 32'h0;
    cx[0] = 7'h55 ^ 7'h01; ox[0] = 7'h55 ^ 7'h01;
    query(0, 1'b1, 1'b0, 0);
    idle(0, 1);

    // Mismatch ckt=0x01, oracle=0x00 via requester 1.
    r1pi[0] = 36'h0_0000_0040; r1key[0] = 32'h0000_0003;
    cx[0] = 7'h01 ^ 7'h40 ^ 7'h03; ox[0] = 7'h40;
    query(0, 1'b0, 1'b1, 0);
    idle(0, 1);

    // Backpressure: 10 stalled cycles with both requesters waiting.
    r0pi[0] = 36'ha_5a5a_5a5a; r1pi[0] = 36'h5_a5a5_a5a5;
    query(0, 1'b1, 1'b1, 10);
    idle(0, 2);

    // Random queries.
    for (int i = 0; i < 20; i++) begin
      vv = 2'($urandom_range(1, 3));
      r0pi[0] = {4'($urandom), $urandom}; r1pi[0] = {4'($urandom), $urandom};
      r0key[0] = $urandom; r1key[0] = {r0key[0][31:7] ^ 25'($urandom), r0key[0][6:0]};
      cx[0] = 7'($urandom);
      ox[0] = ($urandom_range(0, 1) == 1) ? (r0key[0][6:0] ^ cx[0]) : 7'($urandom);
      query(0, vv[0], vv[1], int'($urandom_range(0, 3)));
      idle(0, int'($urandom_range(1, 2)));
    end

    // Saturation on the 2-bit counters: five mismatching queries.
    for (int i = 0; i < 5; i++) begin
      r0pi[1] = {4'($urandom), $urandom}; r0key[1] = $urandom;
      cx[1] = 7'($urandom); ox[1] = cx[1] ^ r0key[1][6:0] ^ 7'h01;
      query(1, 1'b1, 1'b0, 0);
      idle(1, 1);
    end

    // Reset in DRIVE, then a normal query afterwards.
    r0pi[1] = 36'hf_0f0f_0f0f; r0key[1] = 32'h1234_5678;
    reset_mid(1, 2);
    r0pi[1] = 36'h3_3333_3333; r1pi[1] = 36'hc_cccc_cccc; r1key[1] = 32'h8765_4321;
    cx[1] = 7'h0f; ox[1] = 7'h0f ^ 7'h21;
    query(1, 1'b1, 1'b1, 1);
    idle(1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
